pll_acq_ctrl: RTL

// - Acquisition/lock sequencer for the SWIPT PLL. Sits between Heartbeat (swiptAlive) and PLL/SwiptOut.
// - Drives the PLL freq/load_freq/lgcoefficient configuration and ramps the SwiptOut duty word l.
// - Declares lock, detects loss of lock, retries acquisition at offset frequencies, flags hard failure.

---
 rtl/pll_ctrl_pkg.sv | 46 ++++
 rtl/duty_softstart.sv | 45 ++++
 rtl/pll_acq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared definitions for the SWIPT PLL acquisition sequencer.
//   - pll_state_e : sequencer state encoding (also exported on the debug port)
//   - pll_err_e   : PLL phase-error codes
//   - default freq / loop-gain / duty constants shared with SwiptOut and PLL
//   - helpers for saturating counters and "==" threshold detection
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACQUIRE = 3'd3,
    ST_TRACK   = 3'd4,
    ST_FAIL    = 3'd5
  } pll_state_e;

  typedef enum logic [1:0] {
    ERR_IN_PHASE = 2'b00,
    ERR_LEAD     = 2'b01,
    ERR_LAG      = 2'b10,
    ERR_NO_EDGE  = 2'b11
  } pll_err_e;

  localparam logic [31:0] FREQ_DEFAULT_C = 32'h0000_9C40;
  localparam logic [31:0] FREQ_STEP_C    = 32'h0000_0100;
  localparam logic [4:0]  LGC_ACQ_C      = 5'd12;
  localparam logic [4:0]  LGC_TRACK_C    = 5'd16;
  localparam logic [11:0] DUTY_TARGET_C  = 12'h0FA;
  localparam logic [11:0] DUTY_STEP_C    = 12'd1;

  // A counter holds the number of qualifying cycles already seen, so the
  // current cycle completes the run when cnt == thr-1. A threshold of 0
  // still costs one cycle.
  function automatic logic at_limit(input logic [31:0] cnt, input logic [31:0] thr);
    return (thr == 32'd0) || (cnt == thr - 32'd1);
  endfunction

  function automatic logic [15:0] inc16_sat(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [23:0] inc24_sat(input logic [23:0] v);
    return (&v) ? v : v + 24'd1;
  endfunction

endpackage

// File: rtl/duty_softstart.sv
// duty_softstart: soft-start ramp for the SwiptOut duty word.
//   clk, nrst : clock, asynchronous active-low reset
//   en        : advance the RAMP_DIV divider this cycle (ramp states)
//   clr       : force duty to 0 and clear the divider (wins over en)
//   duty      : registered duty word, rises by DUTY_STEP every RAMP_DIV
//               enabled cycles and saturates at DUTY_TARGET
// With en=0 and clr=0 both duty and divider hold their value.
module duty_softstart
  import pll_ctrl_pkg::*;
#(
  parameter logic [15:0] RAMP_DIV    = 16'd100,
  parameter logic [11:0] DUTY_STEP   = DUTY_STEP_C,
  parameter logic [11:0] DUTY_TARGET = DUTY_TARGET_C
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        clr,
  output logic [11:0] duty
);

  logic [15:0] div_cnt;
  logic        tick;
  logic [12:0] sum;

  assign tick = en && at_limit(32'(div_cnt), 32'(RAMP_DIV));
  // One extra bit so a large step cannot wrap past the target.
  assign sum  = {1'b0, duty} + {1'b0, DUTY_STEP};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
      duty    <= '0;
    end else if (clr) begin
      div_cnt <= '0;
      duty    <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      duty    <= (sum >= {1'b0, DUTY_TARGET}) ? DUTY_TARGET : sum[11:0];
    end else if (en) begin
      div_cnt <= inc16_sat(div_cnt);
    end
  end

endmodule

// File: rtl/pll_acq_ctrl.sv
// pll_acq_ctrl: acquisition/lock sequencer between Heartbeat and PLL/SwiptOut.
//   clk, nrst     : 100 MHz clock, asynchronous active-low reset
//   swiptAlive    : link alive; 0 returns the sequencer to IDLE (highest priority)
//   pll_err       : PLL phase error, 00 = in phase
//   freq_out      : PLL/SwiptOut freq word, FREQ_DEFAULT + retry_cnt*FREQ_STEP at load
//   load_freq     : one-cycle load strobe, high exactly while in LOAD
//   lgcoefficient : loop gain shift, LGC_TRACK in TRACK, LGC_ACQ otherwise
//   duty_l        : SwiptOut duty word from the soft-start ramp
//   locked        : high while in TRACK
//   acq_fail      : high while in FAIL
//   retry_cnt     : failed attempts since last IDLE or lock loss
//   dbg_state     : current sequencer state (pll_state_e encoding)
// Every output is a register loaded from the next-state decision, so each
// output is valid in the same cycle as the state it describes.
module pll_acq_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter logic [31:0] FREQ_DEFAULT = FREQ_DEFAULT_C,
  parameter logic [31:0] FREQ_STEP    = FREQ_STEP_C,
  parameter logic [4:0]  LGC_ACQ      = LGC_ACQ_C,
  parameter logic [4:0]  LGC_TRACK    = LGC_TRACK_C,
  parameter logic [11:0] DUTY_TARGET  = DUTY_TARGET_C,
  parameter logic [11:0] DUTY_STEP    = DUTY_STEP_C,
  parameter logic [15:0] RAMP_DIV     = 16'd100,
  parameter logic [15:0] SETTLE_CYC   = 16'd1000,
  parameter logic [15:0] LOCK_CNT     = 16'd256,
  parameter logic [15:0] UNLOCK_CNT   = 16'd64,
  parameter logic [23:0] ACQ_TIMEOUT  = 24'd100000,
  parameter logic [2:0]  MAX_RETRY    = 3'd3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [1:0]  pll_err,
  output logic [31:0] freq_out,
  output logic        load_freq,
  output logic [4:0]  lgcoefficient,
  output logic [11:0] duty_l,
  output logic        locked,
  output logic        acq_fail,
  output logic [2:0]  retry_cnt,
  output logic [2:0]  dbg_state
);

  pll_state_e  state, state_n;
  logic [15:0] settle_cnt, settle_cnt_n;
  logic [15:0] lock_cnt, lock_cnt_n;
  logic [15:0] unlock_cnt, unlock_cnt_n;
  logic [23:0] tmo_cnt, tmo_cnt_n;
  logic [2:0]  retry_n;
  logic        in_phase, settle_done, lock_hit, tmo_hit, unlock_hit;
  logic        ramp_en, ramp_clr;

  assign in_phase    = (pll_err == ERR_IN_PHASE);
  assign settle_done = at_limit(32'(settle_cnt), 32'(SETTLE_CYC));
  assign lock_hit    = in_phase && at_limit(32'(lock_cnt), 32'(LOCK_CNT));
  assign tmo_hit     = at_limit(32'(tmo_cnt), 32'(ACQ_TIMEOUT));
  assign unlock_hit  = !in_phase && at_limit(32'(unlock_cnt), 32'(UNLOCK_CNT));
  assign dbg_state   = state;

  // Next-state logic. Counters default to zero so every state entry starts
  // from a clean count; only the owning state keeps its counter running.
  always_comb begin
    state_n      = state;
    settle_cnt_n = '0;
    lock_cnt_n   = '0;
    unlock_cnt_n = '0;
    tmo_cnt_n    = '0;
    retry_n      = retry_cnt;
    if (!swiptAlive) begin
      state_n = ST_IDLE;
      retry_n = '0;
    end else begin
      unique case (state)
        ST_IDLE:   state_n = ST_LOAD;
        ST_LOAD:   state_n = ST_SETTLE;
        ST_SETTLE: begin
          if (settle_done) state_n = ST_ACQUIRE;
          else             settle_cnt_n = inc16_sat(settle_cnt);
        end
        ST_ACQUIRE: begin
          // Lock is checked first: a lock on the timeout cycle still counts.
          if (lock_hit) begin
            state_n = ST_TRACK;
          end else if (tmo_hit) begin
            retry_n = (&retry_cnt) ? retry_cnt : retry_cnt + 3'd1;
            state_n = (retry_n == MAX_RETRY) ? ST_FAIL : ST_LOAD;
          end else begin
            lock_cnt_n = in_phase ? inc16_sat(lock_cnt) : 16'd0;
            tmo_cnt_n  = inc24_sat(tmo_cnt);
          end
        end
        ST_TRACK: begin
          if (unlock_hit) begin
            retry_n = '0;
            state_n = ST_LOAD;
          end else begin
            unlock_cnt_n = in_phase ? 16'd0 : inc16_sat(unlock_cnt);
          end
        end
        ST_FAIL:   state_n = ST_FAIL;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      lock_cnt      <= '0;
      unlock_cnt    <= '0;
      tmo_cnt       <= '0;
      retry_cnt     <= '0;
      freq_out      <= FREQ_DEFAULT;
      load_freq     <= 1'b0;
      lgcoefficient <= LGC_ACQ;
      locked        <= 1'b0;
      acq_fail      <= 1'b0;
    end else begin
      state         <= state_n;
      settle_cnt    <= settle_cnt_n;
      lock_cnt      <= lock_cnt_n;
      unlock_cnt    <= unlock_cnt_n;
      tmo_cnt       <= tmo_cnt_n;
      retry_cnt     <= retry_n;
      load_freq     <= (state_n == ST_LOAD);
      lgcoefficient <= (state_n == ST_TRACK) ? LGC_TRACK : LGC_ACQ;
      locked        <= (state_n == ST_TRACK);
      acq_fail      <= (state_n == ST_FAIL);
      // Freq word changes only when a new attempt is loaded or the link drops;
      // the sum wraps modulo 2^32.
      if (state_n == ST_LOAD)
        freq_out <= FREQ_DEFAULT + FREQ_STEP * 32'(retry_n);
      else if (state_n == ST_IDLE)
        freq_out <= FREQ_DEFAULT;
    end
  end

  // The ramp advances on cycles spent in SETTLE/ACQUIRE/TRACK, holds through
  // LOAD, and is cleared on the edge that enters IDLE or FAIL so duty_l is
  // already 0 in the first cycle of those states.
  assign ramp_en  = (state == ST_SETTLE) || (state == ST_ACQUIRE) || (state == ST_TRACK);
  assign ramp_clr = (state_n == ST_IDLE) || (state_n == ST_FAIL);

  duty_softstart #(
    .RAMP_DIV    (RAMP_DIV),
    .DUTY_STEP   (DUTY_STEP),
    .DUTY_TARGET (DUTY_TARGET)
  ) u_softstart (
    .clk  (clk),
    .nrst (nrst),
    .en   (ramp_en),
    .clr  (ramp_clr),
    .duty (duty_l)
  );

endmodule
